// File: rtl/sha256_nonce_scanner.sv
// sha256_nonce_scanner
//   Issues one nonce per cycle into a fixed-latency, stall-free SHA-256
//   pipeline. It tests each returned hash word against zero. On a zero it
//   recovers the nonce that produced the hash and queues it for the host.
//
// Ports
//   clk           clock
//   reset_n       asynchronous active-low reset
//   start         one-cycle pulse: load nonce_base and (re)start a scan
//   nonce_base    first nonce of the scan
//   nonce         nonce currently driven into the pipeline
//   hash_word     pipeline output word; zero marks a golden candidate
//   busy          scan in progress (RUN or DRAIN)
//   done          one-cycle pulse when a scan completes
//   golden_valid  golden-nonce queue is not empty
//   golden_nonce  queue head (holds its last value when the queue empties)
//   golden_ready  reader pops the head when golden_valid is also high
//   overflow      sticky: a golden nonce was dropped because the queue was full
module sha256_nonce_scanner #(
  parameter int LATENCY    = 128,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] nonce_base,
  output logic [31:0] nonce,
  input  logic [31:0] hash_word,
  output logic        busy,
  output logic        done,
  output logic        golden_valid,
  output logic [31:0] golden_nonce,
  input  logic        golden_ready,
  output logic        overflow
);

  localparam int CW = $clog2(LATENCY + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] LAT_C      = CW'(LATENCY);
  localparam logic [CW-1:0] LAST_DRAIN = CW'(LATENCY - 1);
  localparam logic [AW:0]   DEPTH_C    = (AW + 1)'(FIFO_DEPTH);
  localparam logic [31:0]   LAT_W      = 32'(LATENCY);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t        state_q;
  logic [31:0]   nonce_q;
  logic [CW-1:0] fill_q;
  logic [CW-1:0] drain_q;
  logic          busy_q;
  logic          done_q;
  logic          overflow_q;

  // Golden-nonce queue
  logic [31:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [31:0]   golden_nonce_q, golden_nonce_d;

  logic        check_en;
  logic        match;
  logic        full;
  logic        pop;
  logic        push;
  logic        drop;
  logic [31:0] recovered;

  assign nonce        = nonce_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign overflow     = overflow_q;
  assign golden_valid = (count_q != '0);
  assign golden_nonce = golden_nonce_q;

  // Only test once the pipeline has been refilled since the last start, so
  // hashes of nonces from an earlier scan never reach the queue.
  assign check_en  = busy_q && (fill_q == LAT_C);
  assign match     = check_en && (hash_word == 32'h0);
  // nonce advances exactly once per busy cycle, so the nonce that produced
  // the current hash is LATENCY behind.
  assign recovered = nonce_q - LAT_W;

  assign full = (count_q == DEPTH_C);
  assign pop  = golden_valid && golden_ready;
  assign push = match && (!full || pop);
  assign drop = match && full && !pop;

  always_comb begin
    rd_ptr_d       = rd_ptr_q;
    wr_ptr_d       = wr_ptr_q;
    count_d        = count_q;
    golden_nonce_d = golden_nonce_q;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
    // The head is registered: a push into an empty queue shows up on the next
    // cycle, and the last value is kept once the queue drains.
    if (count_d != '0) begin
      if (push && (wr_ptr_q == rd_ptr_d)) golden_nonce_d = recovered;
      else                                golden_nonce_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= recovered;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q       <= '0;
      wr_ptr_q       <= '0;
      count_q        <= '0;
      golden_nonce_q <= 32'h0;
    end else begin
      rd_ptr_q       <= rd_ptr_d;
      wr_ptr_q       <= wr_ptr_d;
      count_q        <= count_d;
      golden_nonce_q <= golden_nonce_d;
    end
  end

  // Scan control FSM
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      nonce_q    <= 32'h0;
      fill_q     <= '0;
      drain_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (drop) overflow_q <= 1'b1;
      if (start) begin
        // Also covers a restart while busy and a start on the final DRAIN
        // cycle: no done pulse, queue untouched.
        state_q    <= S_RUN;
        nonce_q    <= nonce_base;
        fill_q     <= '0;
        busy_q     <= 1'b1;
        overflow_q <= 1'b0;
      end else begin
        case (state_q)
          S_RUN: begin
            nonce_q <= nonce_q + 32'h1;
            if (fill_q != LAT_C) fill_q <= fill_q + 1'b1;
            if (nonce_q == 32'hFFFF_FFFF) begin
              state_q <= S_DRAIN;
              drain_q <= '0;
            end
          end
          S_DRAIN: begin
            // Keep advancing nonce so the recovered-nonce arithmetic still
            // holds for hashes still in flight.
            nonce_q <= nonce_q + 32'h1;
            if (fill_q != LAT_C) fill_q <= fill_q + 1'b1;
            if (drain_q == LAST_DRAIN) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              drain_q <= drain_q + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sha256_nonce_scanner.sv
// Testbench for sha256_nonce_scanner with LATENCY=8, FIFO_DEPTH=4.
// The hash pipeline is modelled as an 8-stage delay line of nonce. hash_word
// is zero when the delayed nonce is in the target set, otherwise 1.
module tb_sha256_nonce_scanner;

  localparam int LAT = 8;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [31:0] nonce_base;
  logic [31:0] nonce;
  logic [31:0] hash_word;
  logic        busy;
  logic        done;
  logic        golden_valid;
  logic [31:0] golden_nonce;
  logic        golden_ready;
  logic        overflow;

  int tests = 0;
  int fails = 0;

  logic [31:0] dl  [LAT];
  logic [31:0] tgt [8];
  int          tgt_n = 0;

  sha256_nonce_scanner #(.LATENCY(LAT), .FIFO_DEPTH(4)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .nonce_base   (nonce_base),
    .nonce        (nonce),
    .hash_word    (hash_word),
    .busy         (busy),
    .done         (done),
    .golden_valid (golden_valid),
    .golden_nonce (golden_nonce),
    .golden_ready (golden_ready),
    .overflow     (overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    dl[0] <= nonce;
    for (int i = 1; i < LAT; i++) dl[i] <= dl[i-1];
  end

  always_comb begin
    hash_word = 32'h1;
    for (int i = 0; i < 8; i++)
      if (i < tgt_n && dl[LAT-1] == tgt[i]) hash_word = 32'h0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [31:0] b);
    nonce_base = b;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Restart with base FFFFFFFF to end the scan: one nonce plus 8 DRAIN cycles.
  task automatic finish_scan();
    int k;
    tgt_n = 0;
    pulse_start(32'hFFFF_FFFF);
    k = 0;
    while (!done && k < 20) begin tick(); k++; end
    tests++;
    if (k !== 9) begin
      fails++;
      $display("FAIL finish_scan_done_latency: got %0d cycles, expected 9", k);
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL finish_scan_busy: got %b, expected 0", busy);
    end
    $display("[TB] finish_scan: done after %0d cycles", k);
  endtask

  task automatic test_reset();
    tests++;
    if (nonce !== 32'h0 || busy !== 1'b0 || done !== 1'b0 || golden_valid !== 1'b0 ||
        golden_nonce !== 32'h0 || overflow !== 1'b0) begin
      fails++;
      $display("FAIL reset_values: nonce=%h busy=%b done=%b gv=%b gn=%h ovf=%b, expected all 0",
               nonce, busy, done, golden_valid, golden_nonce, overflow);
    end
    $display("[TB] test_reset: checked reset values");
  endtask

  task automatic test_single_hit();
    int k;
    tgt[0] = 32'h1005; tgt_n = 1;
    pulse_start(32'h1000);
    tests++;
    if (busy !== 1'b1 || nonce !== 32'h1000) begin
      fails++;
      $display("FAIL single_start: busy=%b nonce=%h, expected 1/00001000", busy, nonce);
    end
    k = 0;
    while (!golden_valid && k < 30) begin tick(); k++; end
    tests++;
    if (k !== 14) begin
      fails++;
      $display("FAIL single_latency: got %0d cycles, expected 14", k);
    end
    tests++;
    if (golden_nonce !== 32'h1005 || overflow !== 1'b0) begin
      fails++;
      $display("FAIL single_value: gn=%h ovf=%b, expected 00001005/0", golden_nonce, overflow);
    end
    golden_ready = 1'b1; tick(); golden_ready = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    tests++;
    if (golden_valid !== 1'b0) begin
      fails++;
      $display("FAIL single_one_entry: golden_valid=%b, expected 0", golden_valid);
    end
    $display("[TB] test_single_hit: valid after %0d cycles, nonce %h", k, 32'h1005);
    finish_scan();
  endtask

  task automatic test_stale();
    int seen;
    tgt[0] = 32'h2003; tgt_n = 1;
    pulse_start(32'h2000);
    for (int i = 0; i < 4; i++) tick();
    pulse_start(32'h5000);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (golden_valid) seen++;
    end
    tests++;
    if (seen !== 0) begin
      fails++;
      $display("FAIL stale_suppress: golden_valid high %0d cycles (gn=%h), expected 0",
               seen, golden_nonce);
    end
    $display("[TB] test_stale: in-flight hit after restart ignored");
    finish_scan();
  endtask

  task automatic test_queue_full();
    logic [31:0] exp_q [4];
    exp_q[0] = 32'h101; exp_q[1] = 32'h102; exp_q[2] = 32'h103; exp_q[3] = 32'h108;
    golden_ready = 1'b0;
    tgt[0] = 32'h100; tgt[1] = 32'h101; tgt[2] = 32'h102;
    tgt[3] = 32'h103; tgt[4] = 32'h104; tgt[5] = 32'h108; tgt_n = 6;
    pulse_start(32'h100);
    for (int i = 0; i < 12; i++) tick();
    tests++;
    if (overflow !== 1'b0 || golden_valid !== 1'b1 || golden_nonce !== 32'h100) begin
      fails++;
      $display("FAIL full_fill: ovf=%b gv=%b gn=%h, expected 0/1/00000100",
               overflow, golden_valid, golden_nonce);
    end
    tick();
    tests++;
    if (overflow !== 1'b1) begin
      fails++;
      $display("FAIL full_overflow: got %b, expected 1", overflow);
    end
    for (int i = 0; i < 3; i++) tick();
    // Hit for 0x108 is being tested this cycle; pop at the same time.
    golden_ready = 1'b1; tick(); golden_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (golden_valid !== 1'b1 || golden_nonce !== exp_q[i]) begin
        fails++;
        $display("FAIL full_order[%0d]: gv=%b gn=%h, expected 1/%h",
                 i, golden_valid, golden_nonce, exp_q[i]);
      end
      $display("[TB] test_queue_full: pop %0d nonce %h", i, golden_nonce);
      golden_ready = 1'b1; tick(); golden_ready = 1'b0;
    end
    tests++;
    if (golden_valid !== 1'b0 || overflow !== 1'b1) begin
      fails++;
      $display("FAIL full_after_drain: gv=%b ovf=%b, expected 0/1", golden_valid, overflow);
    end
    tgt_n = 0;
    pulse_start(32'hFFFF_FFFF);
    tests++;
    if (overflow !== 1'b0) begin
      fails++;
      $display("FAIL full_ovf_clear: got %b, expected 0", overflow);
    end
    for (int i = 0; i < 12; i++) tick();
  endtask

  task automatic test_end_of_range();
    int k;
    tgt[0] = 32'hFFFF_FFFE; tgt_n = 1;
    pulse_start(32'hFFFF_FFFC);
    k = 0;
    while (!done && k < 30) begin tick(); k++; end
    tests++;
    if (k !== 12 || busy !== 1'b0) begin
      fails++;
      $display("FAIL eor_done: got %0d cycles busy=%b, expected 12/0", k, busy);
    end
    tests++;
    if (nonce !== 32'h8) begin
      fails++;
      $display("FAIL eor_wrap: nonce=%h, expected 00000008", nonce);
    end
    tests++;
    if (golden_valid !== 1'b1 || golden_nonce !== 32'hFFFF_FFFE) begin
      fails++;
      $display("FAIL eor_value: gv=%b gn=%h, expected 1/fffffffe", golden_valid, golden_nonce);
    end
    tick();
    tests++;
    if (done !== 1'b0) begin
      fails++;
      $display("FAIL eor_done_pulse: done=%b one cycle later, expected 0", done);
    end
    $display("[TB] test_end_of_range: done after %0d cycles, nonce %h", k, golden_nonce);
    golden_ready = 1'b1; tick(); golden_ready = 1'b0;
    tgt_n = 0;
  endtask

  task automatic test_restart();
    int k;
    int saw_done;
    tgt[0] = 32'h11; tgt[1] = 32'h82; tgt_n = 2;
    saw_done = 0;
    pulse_start(32'h10);
    for (int i = 0; i < 3; i++) begin tick(); if (done) saw_done++; end
    pulse_start(32'h80);
    if (done) saw_done++;
    k = 0;
    while (!golden_valid && k < 30) begin tick(); k++; end
    tests++;
    if (golden_nonce !== 32'h82 || k !== 11) begin
      fails++;
      $display("FAIL restart_value: gn=%h after %0d cycles, expected 00000082 after 11",
               golden_nonce, k);
    end
    tests++;
    if (saw_done !== 0) begin
      fails++;
      $display("FAIL restart_no_done: done seen %0d times, expected 0", saw_done);
    end
    golden_ready = 1'b1; tick(); golden_ready = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    tests++;
    if (golden_valid !== 1'b0) begin
      fails++;
      $display("FAIL restart_single: gv=%b gn=%h, expected 0", golden_valid, golden_nonce);
    end
    $display("[TB] test_restart: queued %h", 32'h82);
    finish_scan();
  endtask

  task automatic test_async_reset();
    tgt[0] = 32'h301; tgt[1] = 32'h302; tgt_n = 2;
    pulse_start(32'h300);
    for (int i = 0; i < 12; i++) tick();
    tests++;
    if (golden_valid !== 1'b1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL areset_setup: gv=%b busy=%b, expected 1/1", golden_valid, busy);
    end
    #2;
    reset_n = 1'b0;
    #1;
    tests++;
    if (golden_valid !== 1'b0 || busy !== 1'b0 || overflow !== 1'b0 || nonce !== 32'h0) begin
      fails++;
      $display("FAIL areset_immediate: gv=%b busy=%b ovf=%b nonce=%h, expected 0/0/0/0",
               golden_valid, busy, overflow, nonce);
    end
    tgt_n = 0;
    tick();
    reset_n = 1'b1;
    tick(); tick();
    tests++;
    if (golden_valid !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL areset_after: gv=%b busy=%b, expected 0/0", golden_valid, busy);
    end
    $display("[TB] test_async_reset: cleared mid-scan");
  endtask

  initial begin
    reset_n      = 1'b0;
    start        = 1'b0;
    nonce_base   = 32'h0;
    golden_ready = 1'b0;
    tick(); tick();
    test_reset();
    reset_n = 1'b1;
    tick();
    test_reset();
    test_single_hit();
    test_stale();
    test_queue_full();
    test_end_of_range();
    test_restart();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
